// File: rtl/adiabatic_pclk_gen.sv
// Multi-phase trapezoidal power-clock sequencer for the adiabatic prefix cells of the MIPS25 ALU.
// Define PCLK_LEVEL_OUT_EN to add the per-phase ramp level output port.
module adiabatic_pclk_gen #(
   parameter int unsigned NPHASE      = 4,
   parameter int unsigned RAMP_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned LEVEL_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [NPHASE-1:0] pclkpos,
   output logic [NPHASE-1:0] pclkneg,
   output logic [NPHASE-1:0] eval,
   output logic              busy,
   output logic              done
`ifdef PCLK_LEVEL_OUT_EN
   ,
   output logic [NPHASE*LEVEL_W-1:0] level
`endif
);

   localparam int unsigned T        = 2*RAMP_CYCLES + 2*HOLD_CYCLES;
   localparam int unsigned Q        = T / NPHASE;
   localparam int unsigned CNT_W    = (T > 1) ? $clog2(T) : 1;
   localparam int unsigned HOLD_END = RAMP_CYCLES + HOLD_CYCLES;
   localparam int unsigned RDN_END  = 2*RAMP_CYCLES + HOLD_CYCLES;

   if ((T % NPHASE) != 0) begin : g_bad_period
      $error("adiabatic_pclk_gen: period %0d not divisible by NPHASE %0d", T, NPHASE);
   end
   if (LEVEL_W == 0) begin : g_bad_level
      $error("adiabatic_pclk_gen: LEVEL_W must be at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
   logic [NPHASE-1:0] active, active_nxt;

   assign cnt_inc = (cnt == CNT_W'(T-1)) ? '0 : cnt + CNT_W'(1);

   // Phases join or leave only on the edge that starts their ramp-up, so nothing is truncated.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      active_nxt = active;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            cnt_nxt = cnt_inc;
            if (stop) state_nxt = S_DRAIN;
         end
         S_DRAIN: cnt_nxt = cnt_inc;
         default: state_nxt = S_IDLE;
      endcase
      for (int unsigned k = 0; k < NPHASE; k++) begin
         if (cnt_nxt == CNT_W'(k*Q)) active_nxt[k] = (state_nxt == S_RUN);
      end
      if ((state == S_DRAIN) && (active_nxt == '0)) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         active <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         active <= active_nxt;
         done   <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      end
   end

   assign busy    = (state != S_IDLE);
   assign pclkneg = ~pclkpos;

`ifdef PCLK_LEVEL_OUT_EN
   localparam int unsigned MAX = (2**LEVEL_W) - 1;
`endif

   for (genvar k = 0; k < NPHASE; k++) begin : g_phase
      localparam int unsigned OFF = k * Q;
      logic [CNT_W:0]   diff;
      logic [CNT_W-1:0] lc;

      // Local count (cnt - OFF) mod T; the borrow bit selects the wrapped value.
      assign diff = {1'b0, cnt} - (CNT_W+1)'(OFF);
      assign lc   = diff[CNT_W] ? CNT_W'(diff + (CNT_W+1)'(T)) : diff[CNT_W-1:0];

      assign pclkpos[k] = active[k] && (lc < CNT_W'(RDN_END));
      assign eval[k]    = active[k] && (lc >= CNT_W'(RAMP_CYCLES)) && (lc < CNT_W'(HOLD_END));

`ifdef PCLK_LEVEL_OUT_EN
      logic [LEVEL_W-1:0] lvl;
      always_comb begin
         lvl = '0;
         if (!active[k] || (lc >= CNT_W'(RDN_END))) begin
            lvl = '0;
         end else if (lc < CNT_W'(RAMP_CYCLES)) begin
            lvl = LEVEL_W'(((32'(lc) + 32'd1) * MAX) / RAMP_CYCLES);
         end else if (lc < CNT_W'(HOLD_END)) begin
            lvl = LEVEL_W'(MAX);
         end else begin
            lvl = LEVEL_W'(MAX - (((32'(lc) - HOLD_END + 32'd1) * MAX) / RAMP_CYCLES));
         end
      end
      assign level[k*LEVEL_W +: LEVEL_W] = lvl;
`endif
   end

endmodule
